mem_access_arbiter: RTL

// Two-port arbiter/sequencer in front of the memory_access unit of the pipelined CPU.

---
 rtl/mem_access_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-port round-robin sequencer in front of memory_access
module mem_access_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 48,
  parameter int CTRL_W  = 3,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [CTRL_W-1:0] CTRL0,
  input  logic [CTRL_W-1:0] CTRL1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_ENABLE,
  output logic [CTRL_W-1:0] MEM_CTRL,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  input  logic [DATA_W-1:0] MEM_READ,
  output logic              BUSY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic              owner;
  logic              last_owner;
  logic [3:0]        wait_cnt;
  logic [CTRL_W-1:0] lat_ctrl;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] rdata_q;
  logic              pick;
  logic              in_issue;
  logic              in_wait;
  logic              in_resp;

  // On a tie the port that lost last time wins; a lone request always wins.
  assign pick = (REQ0 && REQ1) ? ~last_owner : REQ1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wait_cnt   <= 4'd0;
      lat_ctrl   <= '0;
      lat_addr   <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            owner      <= pick;
            last_owner <= pick;
            lat_ctrl   <= pick ? CTRL1 : CTRL0;
            lat_addr   <= pick ? ADDR1 : ADDR0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= 4'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rdata_q <= MEM_READ;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so an async reset clears them at once.
  assign in_issue = (state == S_ISSUE);
  assign in_wait  = (state == S_WAIT);
  assign in_resp  = (state == S_RESP);

  assign GNT0        = in_issue && !owner;
  assign GNT1        = in_issue && owner;
  assign RVALID0     = in_resp && !owner;
  assign RVALID1     = in_resp && owner;
  assign MEM_ENABLE  = in_issue || in_wait;
  assign MEM_CTRL    = MEM_ENABLE ? lat_ctrl : '0;
  assign MEM_ADDRESS = MEM_ENABLE ? lat_addr : '0;
  assign RDATA       = rdata_q;
  assign BUSY        = (state != S_IDLE);

endmodule
